// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state and owner encodings for the memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned WORD  = 32;
  localparam int unsigned ADDR  = 16;
  // Holds MEM_LAT-1 for MEM_LAT in 1..4.
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnD  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-port signals of the arbiter. Suffixes are from the arbiter's view.
interface mem_arbiter_if import mem_arbiter_pkg::*; ();

  logic            if_req_i;
  logic [ADDR-1:0] if_addr_i;
  logic            if_flush_i;
  logic            if_ack_o;
  logic [WORD-1:0] if_inst_o;
  logic            if_stall_o;

  logic            d_req_i;
  logic            d_we_i;
  logic [ADDR-1:0] d_addr_i;
  logic [WORD-1:0] d_wdata_i;
  logic            d_done_o;
  logic [WORD-1:0] d_rdata_o;

  logic            mem_en_o;
  logic            mem_we_o;
  logic [ADDR-1:0] mem_addr_o;
  logic [WORD-1:0] mem_wdata_o;
  logic [WORD-1:0] mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i, if_flush_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output if_ack_o, if_inst_o, if_stall_o, d_done_o, d_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Requesters and memory side.
  modport master (
    output if_req_i, if_addr_i, if_flush_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  if_ack_o, if_inst_o, if_stall_o, d_done_o, d_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// Memory latency countdown: load, decrement, zero flag.
module mem_arbiter_lat_counter import mem_arbiter_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int unsigned MEM_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(MEM_LAT - 1);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_q, last_d;
  logic            we_lat_q, we_lat_d;
  logic            flushed_q, flushed_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [WORD-1:0] mem_wdata_q, mem_wdata_d;
  logic            if_ack_q, if_ack_d;
  logic [WORD-1:0] if_inst_q, if_inst_d;
  logic            d_done_q, d_done_d;
  logic [WORD-1:0] d_rdata_q, d_rdata_d;

  logic cnt_load, cnt_dec, cnt_zero;
  logic flush_hit;
  logic grant_data;

  mem_arbiter_lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (LoadVal),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // A flush only matters while a fetch owns the memory port.
  assign flush_hit = bus.if_flush_i && (owner_q == OwnIf) && (state_q != StIdle);

  // Next-state, arbitration and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_lat_d    = we_lat_q;
    flushed_d   = flushed_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_inst_d   = if_inst_q;
    d_done_d    = 1'b0;
    d_rdata_d   = d_rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    grant_data  = 1'b0;

    unique case (state_q)
      StIdle: begin
        flushed_d = 1'b0;
        if (bus.if_req_i || bus.d_req_i) begin
          // Data wins only when alone or when fetch was served last.
          grant_data = bus.d_req_i && (!bus.if_req_i || (last_q == OwnIf));
          mem_en_d   = 1'b1;
          state_d    = StIssue;
          if (grant_data) begin
            owner_d     = OwnD;
            we_lat_d    = bus.d_we_i;
            mem_we_d    = bus.d_we_i;
            mem_addr_d  = bus.d_addr_i;
            mem_wdata_d = bus.d_wdata_i;
          end else begin
            owner_d     = OwnIf;
            we_lat_d    = 1'b0;
            mem_addr_d  = bus.if_addr_i;
            mem_wdata_d = '0;
          end
        end
      end
      StIssue: begin
        cnt_load = 1'b1;
        state_d  = StWait;
        if (flush_hit) flushed_d = 1'b1;
      end
      StWait: begin
        if (flush_hit) flushed_d = 1'b1;
        if (cnt_zero) begin
          if (owner_q == OwnIf) begin
            if (!flushed_q && !flush_hit) if_inst_d = bus.mem_rdata_i;
          end else if (!we_lat_q) begin
            d_rdata_d = bus.mem_rdata_i;
          end
          state_d = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDone: begin
        if (owner_q == OwnIf) begin
          if_ack_d = !flushed_q && !flush_hit;
        end else begin
          d_done_d = 1'b1;
        end
        last_d  = owner_q;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      last_q      <= OwnD;
      we_lat_q    <= 1'b0;
      flushed_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_inst_q   <= '0;
      d_done_q    <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_lat_q    <= we_lat_d;
      flushed_q   <= flushed_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_inst_q   <= if_inst_d;
      d_done_q    <= d_done_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.if_inst_o   = if_inst_q;
  assign bus.d_done_o    = d_done_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.if_stall_o  = bus.if_req_i & ~if_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, transaction-level model and per-cycle compare.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;

  logic [31:0] tb_mem [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: read data is valid only in the cycle MEM_LAT after the enable cycle.
  initial begin
    int          due;
    logic [7:0]  due_addr;
    due      = -1;
    due_addr = '0;
    bus.mem_rdata_i = 32'hBAD0_0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        due = -1;
      end else if (bus.mem_en_o && !bus.mem_we_o) begin
        due      = cyc + int'(MEM_LAT);
        due_addr = bus.mem_addr_o[7:0];
      end
      bus.mem_rdata_i = (cyc == due) ? tb_mem[due_addr] : (32'hBAD0_0000 ^ 32'(cyc));
    end
  end

  // Transaction-level model: a grant starts a job whose events fall at fixed offsets.
  bit          m_busy, m_own_d, m_we, m_flushed, m_last_d;
  int unsigned m_k;
  logic [15:0] m_addr;
  logic        e_en, e_we, e_ack, e_done;
  logic [15:0] e_addr;
  logic [31:0] e_wdata, e_inst, e_rdata;

  task automatic model_reset();
    m_busy = 0; m_own_d = 0; m_we = 0; m_flushed = 0; m_last_d = 1; m_k = 0; m_addr = '0;
    e_en = 0; e_we = 0; e_ack = 0; e_done = 0;
    e_addr = '0; e_wdata = '0; e_inst = '0; e_rdata = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        e_en = 0; e_we = 0; e_ack = 0; e_done = 0;
        if (m_busy) begin
          if (bus.if_flush_i && !m_own_d) m_flushed = 1;
          m_k++;
          if (m_k == MEM_LAT + 1) begin
            if (!m_own_d && !m_flushed) e_inst = tb_mem[m_addr[7:0]];
            if (m_own_d && !m_we) e_rdata = tb_mem[m_addr[7:0]];
          end
          if (m_k == MEM_LAT + 2) begin
            if (m_own_d) e_done = 1;
            else e_ack = !m_flushed;
            m_last_d = m_own_d;
            m_busy   = 0;
          end
        end else if (bus.if_req_i || bus.d_req_i) begin
          m_own_d   = bus.d_req_i && (!bus.if_req_i || !m_last_d);
          m_busy    = 1;
          m_k       = 0;
          m_flushed = 0;
          e_en      = 1;
          if (m_own_d) begin
            m_we = bus.d_we_i; m_addr = bus.d_addr_i;
            e_we = bus.d_we_i; e_wdata = bus.d_wdata_i;
          end else begin
            m_we = 0; m_addr = bus.if_addr_i;
          end
          e_addr = m_addr;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("mem_en", 32'(bus.mem_en_o), 32'(e_en));
      chk("mem_we", 32'(bus.mem_we_o), 32'(e_we));
      if (e_en) chk("mem_addr", 32'(bus.mem_addr_o), 32'(e_addr));
      if (e_we) chk("mem_wdata", bus.mem_wdata_o, e_wdata);
      chk("if_ack", 32'(bus.if_ack_o), 32'(e_ack));
      chk("d_done", 32'(bus.d_done_o), 32'(e_done));
      chk("if_inst", bus.if_inst_o, e_inst);
      chk("d_rdata", bus.d_rdata_o, e_rdata);
      chk("if_stall", 32'(bus.if_stall_o), 32'(bus.if_req_i & ~e_ack));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the chosen pulse is seen; n = number of edges taken (0 on timeout).
  task automatic wait_pulse(input string name, input bit want_ack, input int limit,
                            output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (want_ack ? bus.if_ack_o : bus.d_done_o) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " mem_en"}, 32'(bus.mem_en_o), 32'd0);
    chk({name, " mem_we"}, 32'(bus.mem_we_o), 32'd0);
    chk({name, " mem_addr"}, 32'(bus.mem_addr_o), 32'd0);
    chk({name, " mem_wdata"}, bus.mem_wdata_o, 32'd0);
    chk({name, " if_ack"}, 32'(bus.if_ack_o), 32'd0);
    chk({name, " if_inst"}, bus.if_inst_o, 32'd0);
    chk({name, " d_done"}, 32'(bus.d_done_o), 32'd0);
    chk({name, " d_rdata"}, bus.d_rdata_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int acks;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    tb_mem[8'h10] = 32'hDEADBEEF;
    tb_mem[8'h30] = 32'hA0A0_0030;
    tb_mem[8'h34] = 32'hA0A0_0034;
    tb_mem[8'h38] = 32'hA0A0_0038;
    tb_mem[8'h40] = 32'hB0B0_0040;
    tb_mem[8'h50] = 32'hC0C0_0050;
    tb_mem[8'h60] = 32'hD0D0_0060;
    tb_mem[8'h70] = 32'hE0E0_0070;
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.if_flush_i = 0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0;

    // Reset state.
    step(); step();
    chk_all_zero("reset");
    rst = 0;
    step();

    // Single fetch: enable one edge after sampling, ack four edges after.
    bus.if_req_i = 1; bus.if_addr_i = 16'h0010;
    step();
    chk("fetch mem_en", 32'(bus.mem_en_o), 32'd1);
    chk("fetch mem_addr", 32'(bus.mem_addr_o), 32'h0010);
    wait_pulse("fetch ack", 1, 10, n);
    chk("fetch ack latency", 32'(n), 32'd4);
    chk("fetch inst", bus.if_inst_o, 32'hDEADBEEF);
    chk("fetch stall at ack", 32'(bus.if_stall_o), 32'd0);
    bus.if_req_i = 0;
    step();

    // Simultaneous pair after reset: fetch first.
    rst = 1; step(); rst = 0; step();
    bus.if_req_i = 1; bus.if_addr_i = 16'h0030;
    bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 16'h0040;
    step();
    chk("pair1 if first", 32'(bus.mem_addr_o), 32'h0030);
    wait_pulse("pair1 ack", 1, 10, n);
    chk("pair1 ack latency", 32'(n), 32'd4);
    // Fetch re-requests at once, forming a second pair with the waiting data access.
    bus.if_addr_i = 16'h0034;
    step();
    chk("pair2 d first en", 32'(bus.mem_en_o), 32'd1);
    chk("pair2 d first addr", 32'(bus.mem_addr_o), 32'h0040);
    wait_pulse("pair2 done", 0, 10, n);
    chk("pair2 done latency", 32'(n), 32'd4);
    chk("pair2 rdata", bus.d_rdata_o, 32'hB0B0_0040);
    bus.d_req_i = 0;
    step();
    chk("pair2 if next addr", 32'(bus.mem_addr_o), 32'h0034);
    wait_pulse("pair2 ack", 1, 10, n);
    chk("pair2 ack latency", 32'(n), 32'd4);
    chk("pair2 inst", bus.if_inst_o, 32'hA0A0_0034);
    bus.if_req_i = 0;
    step();

    // Data write with fetch held: fetch was served last, so the write goes first.
    bus.d_req_i = 1; bus.d_we_i = 1; bus.d_addr_i = 16'h0020; bus.d_wdata_i = 32'h12345678;
    bus.if_req_i = 1; bus.if_addr_i = 16'h0038;
    step();
    chk("write mem_we", 32'(bus.mem_we_o), 32'd1);
    chk("write mem_addr", 32'(bus.mem_addr_o), 32'h0020);
    chk("write mem_wdata", bus.mem_wdata_o, 32'h12345678);
    chk("write stall", 32'(bus.if_stall_o), 32'd1);
    step();
    chk("write we one cycle", 32'(bus.mem_we_o), 32'd0);
    chk("write stall held", 32'(bus.if_stall_o), 32'd1);
    wait_pulse("write done", 0, 10, n);
    chk("write done latency", 32'(n + 1), 32'd4);
    chk("write rdata unchanged", bus.d_rdata_o, 32'hB0B0_0040);
    bus.d_req_i = 0; bus.d_we_i = 0;
    wait_pulse("stalled fetch ack", 1, 12, n);
    chk("stalled fetch ack edges", 32'(n), 32'd5);
    chk("stalled fetch inst", bus.if_inst_o, 32'hA0A0_0038);
    bus.if_req_i = 0;
    step();

    // Flush during WAIT: no ack, instruction unchanged.
    bus.if_req_i = 1; bus.if_addr_i = 16'h0050;
    step(); step();
    bus.if_flush_i = 1; bus.if_req_i = 0;
    step();
    bus.if_flush_i = 0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.if_ack_o) acks++;
    end
    chk("flush ack suppressed", 32'(acks), 32'd0);
    chk("flush inst unchanged", bus.if_inst_o, 32'hA0A0_0038);
    bus.if_req_i = 1; bus.if_addr_i = 16'h0060;
    wait_pulse("post-flush ack", 1, 10, n);
    chk("post-flush ack edges", 32'(n), 32'd5);
    chk("post-flush inst", bus.if_inst_o, 32'hD0D0_0060);
    bus.if_req_i = 0;
    step();

    // Reset during WAIT of a data read; the held request is reissued afterwards.
    bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 16'h0070;
    step(); step();
    #2;
    rst = 1;
    #1;
    chk_all_zero("async reset");
    step();
    rst = 0;
    wait_pulse("reissue done", 0, 10, n);
    chk("reissue done edges", 32'(n), 32'd5);
    chk("reissue rdata", bus.d_rdata_o, 32'hE0E0_0070);
    bus.d_req_i = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD, 32: data/instruction width, from shared params.
REQ-002 Parameter ADDR, 16: word-address width, from shared params.
REQ-003 Parameter MEM_LAT, 2: memory read latency in cycles, legal 1..4.
REQ-004 Port clk, input, 1: single clock; all state changes on posedge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port if_req_i, input, 1; if_addr_i, input, ADDR: fetch request and address.
REQ-007 Port if_flush_i, input, 1: branch taken; discard the in-flight fetch.
REQ-008 Port if_ack_o, output, 1; if_inst_o, output, WORD: fetch complete pulse and instruction.
REQ-009 Port if_stall_o, output, 1: fetch stage must hold.
REQ-010 Port d_req_i, d_we_i, input, 1 each; d_addr_i, input, ADDR; d_wdata_i, input, WORD: data access.
REQ-011 Port d_done_o, output, 1; d_rdata_o, output, WORD: data access complete pulse and read data.
REQ-012 Port mem_en_o, mem_we_o, output, 1 each; mem_addr_o, output, ADDR; mem_wdata_o, output, WORD: single shared memory port.
REQ-013 Port mem_rdata_i, input, WORD: read data, valid MEM_LAT cycles after the mem_en_o cycle.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE; the owner register SHALL be IF or D.
REQ-015 IDLE with any request: latch the owner's addr/we/wdata and go to ISSUE; with no request, stay in IDLE.
REQ-016 Simultaneous requests: grant the requester not served last (round-robin); the last-served register resets to D, so IF wins first.
REQ-017 ISSUE: mem_en_o=1 for exactly one cycle with the latched address/we/wdata; load cnt=MEM_LAT-1; go to WAIT.
REQ-018 WAIT: decrement cnt; at cnt==0, capture mem_rdata_i into if_inst_o (owner IF) or d_rdata_o (owner D, read only); go to DONE.
REQ-019 DONE: pulse if_ack_o or d_done_o for one cycle; set last-served=owner; return to IDLE.
REQ-020 Latency from the request-sampling edge to the done pulse SHALL be MEM_LAT+2 cycles; back-to-back grants SHALL have one IDLE cycle between them.
REQ-021 Writes SHALL take the same path and latency; d_rdata_o SHALL be unchanged on a write.
REQ-022 if_stall_o SHALL equal if_req_i & ~if_ack_o (combinational).
REQ-023 Requesters SHALL hold req/addr/data stable until their done/ack; a request deasserted before grant is withdrawn with no effect.
REQ-024 if_flush_i during ISSUE, WAIT or DONE with owner IF: suppress that if_ack_o and leave if_inst_o unchanged; the memory transaction still completes.
REQ-025 if_flush_i while the owner is D or the FSM is in IDLE SHALL have no effect.
REQ-026 Outputs other than if_stall_o SHALL be registered; mem_we_o=0 whenever mem_en_o=0.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, owner=IF, last-served=D, cnt=0, and all outputs 0, including data/address registers.
REQ-028 Reset mid-transaction SHALL abandon it with no done/ack pulse; after reset release, pending requests are re-arbitrated from IDLE.

Structure
REQ-029 WORD, ADDR and the state encodings SHALL live in the shared params package.
REQ-030 The latency countdown SHALL be one sub-module, lat_counter (load, decrement, zero flag).

Verification (MEM_LAT=2)
REQ-031 Fetch only, addr 0x0010, memory returns 0xDEADBEEF -> mem_en_o one cycle after request; if_ack_o 4 cycles after request; if_inst_o=0xDEADBEEF.
REQ-032 Both request at the same edge after reset -> IF served first, D granted on the cycle after the IF ack; a second simultaneous pair -> D first.
REQ-033 Data write addr 0x0020, wdata 0x12345678 -> mem_we_o=1 with that addr/data for one cycle; d_done_o after 4 cycles; d_rdata_o unchanged.
REQ-034 if_flush_i pulsed during WAIT of a fetch -> no if_ack_o, if_inst_o unchanged; the next fetch completes normally.
REQ-035 rst asserted during WAIT -> all outputs 0 asynchronously; no done pulse; a held d_req_i is reissued from IDLE after release.
REQ-036 if_req_i held while a D access is in progress -> if_stall_o=1 every cycle until if_ack_o.
